// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into words and writes them to imem.
// Optional trailing checksum check enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 24581,
  parameter int unsigned CNT_W     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_rst
);

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [2:0]       state;
  logic [1:0]       bcnt;
  logic [23:0]      lanes;
  logic [CNT_W-1:0] widx;
  logic [CNT_W-1:0] last_idx;
  logic [31:0]      word;
  logic             acc;
  logic             wfull;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum;
`endif

  assign word  = {rx_data, lanes};
  assign acc   = rx_valid && (state == S_LEN || state == S_DATA ||
                              state == S_CSUM);
  assign wfull = acc && (bcnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LEN;
      bcnt       <= 2'd0;
      lanes      <= 24'd0;
      widx       <= '0;
      last_idx   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= 32'd0;
      imem_wdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst    <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= 32'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      // Data-path completion: done follows the final write pulse
      if (state == S_DONE) begin
        done    <= 1'b1;
        cpu_rst <= 1'b0;
      end
      if (acc) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    lanes[7:0]   <= rx_data;
          2'd1:    lanes[15:8]  <= rx_data;
          2'd2:    lanes[23:16] <= rx_data;
          default: ;
        endcase
        if (state == S_LEN)
          busy <= 1'b1;
      end
      if (wfull) begin
        case (state)
          S_LEN: begin
            if (word > MAX_WORDS) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state   <= S_CSUM;
`else
              state   <= S_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              busy    <= 1'b0;
`endif
            end else begin
              state    <= S_DATA;
              widx     <= '0;
              last_idx <= word[CNT_W-1:0] - ONE;
            end
          end
          S_DATA: begin
            imem_we    <= 1'b1;
            imem_waddr <= 32'({widx, 2'b00});
            imem_wdata <= word;
            widx       <= widx + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= sum + word;
            if (widx == last_idx)
              state <= S_CSUM;
`else
            if (widx == last_idx) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end
`endif
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CSUM: begin
            busy <= 1'b0;
            if (word == sum) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a byte-stream image model.
// Build with or without IMEM_LOADER_CHECKSUM_EN to match the DUT.
module tb_imem_loader;

  localparam int unsigned MAXW = 24581;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  int          we_cyc[$];
  int          done_cyc;
  bit          done_seen;

  imem_loader #(.MAX_WORDS(MAXW), .CNT_W(15)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err),
    .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      obs_q.push_back({imem_waddr, imem_wdata});
      we_cyc.push_back(cyc);
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (!rst) begin
      checks++;
      if (cpu_rst !== !done) begin
        errors++;
        $display("FAIL cpu_rst_vs_done got %b want %b", cpu_rst, !done);
      end
    end
  end

  function automatic bq_t add_word(input bq_t b, input logic [31:0] w);
    bq_t r;
    r = b;
    for (int k = 0; k < 4; k++) r.push_back(w[8*k +: 8]);
    return r;
  endfunction

  // Image interpretation straight from the stream format
  function automatic void model(input bq_t b, output bit ed, output bit ee);
    logic [31:0] n, w, s;
    int nn;
    ed = 1'b0;
    ee = 1'b0;
    s  = 32'd0;
    exp_q.delete();
    if (b.size() < 4) return;
    n = {b[3], b[2], b[1], b[0]};
    if (n > MAXW) begin
      ee = 1'b1;
      return;
    end
    nn = int'(n);
    for (int i = 0; i < nn; i++) begin
      if (b.size() < 8 + 4*i) return;
      w = {b[7+4*i], b[6+4*i], b[5+4*i], b[4+4*i]};
      exp_q.push_back({32'(4*i), w});
      s = s + w;
    end
    if (!CSUM) begin
      ed = 1'b1;
      return;
    end
    if (b.size() < 8 + 4*nn) return;
    w = {b[7+4*nn], b[6+4*nn], b[5+4*nn], b[4+4*nn]};
    if (w == s) ed = 1'b1;
    else ee = 1'b1;
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    obs_q.delete();
    we_cyc.delete();
    done_seen = 1'b0;
    rst = 1'b0;
  endtask

  task automatic send(input bq_t b, input int maxgap);
    int g;
    foreach (b[i]) begin
      rx_valid = 1'b1;
      rx_data  = b[i];
      @(negedge clk);
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        rx_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_we, imem_waddr, imem_wdata} !== 65'd0) begin
      errors++;
      $display("FAIL reset_wport got %0h want 0",
               {imem_we, imem_waddr, imem_wdata});
    end
    checks++;
    if ({busy, done, err, cpu_rst} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_status got %b want 0001",
               {busy, done, err, cpu_rst});
    end
  endtask

  task automatic test_basic();
    bq_t b;
    bit ed, ee;
    b = add_word(b, 32'd2);
    b = add_word(b, 32'h13);
    b = add_word(b, 32'h6F);
    if (CSUM) b = add_word(b, 32'h82);
    do_reset();
    rx_valid = 1'b1;
    rx_data  = b[0];
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    send(b[1:$], 2);
    repeat (3) @(negedge clk);
    model(b, ed, ee);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL basic_nwr got %0d want 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 64'h0000_0000_0000_0013) begin
        errors++;
        $display("FAIL basic_w0 got %h want 0000000000000013", obs_q[0]);
      end
      checks++;
      if (obs_q[1] !== 64'h0000_0004_0000_006F) begin
        errors++;
        $display("FAIL basic_w1 got %h want 000000040000006f", obs_q[1]);
      end
    end
    checks++;
    if ({done, err, busy} !== {ed, ee, 1'b0}) begin
      errors++;
      $display("FAIL basic_status got %b want %b",
               {done, err, busy}, {ed, ee, 1'b0});
    end
    if (!CSUM) begin
      checks++;
      if (!done_seen || we_cyc.size() != 2 ||
          done_cyc != we_cyc[we_cyc.size()-1] + 1) begin
        errors++;
        $display("FAIL basic_done_time got %0d want last_we+1 (%0d)",
                 done_cyc, (we_cyc.size() > 0) ? we_cyc[$] + 1 : -1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t b;
    bit ed, ee;
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    b = add_word(b, 32'd3);
    for (int i = 0; i < 3; i++) b = add_word(b, w[i]);
    if (CSUM) b = add_word(b, w[0] + w[1] + w[2]);
    do_reset();
    send(b, 0);
    repeat (3) @(negedge clk);
    model(b, ed, ee);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_nwr got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_w%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (we_cyc[i] - we_cyc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want 4", i,
                   we_cyc[i] - we_cyc[i-1]);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %b want 1", done);
    end
  endtask

  task automatic test_oversize();
    bq_t b;
    b = add_word(b, 32'h0000_6006);
    do_reset();
    send(b, 0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL over_err_time got %b want 1", err);
    end
    b.delete();
    b = add_word(b, 32'h0000_0001);
    b = add_word(b, 32'hDEAD_BEEF);
    send(b, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL over_nwr got %0d want 0", obs_q.size());
    end
    checks++;
    if ({done, err, busy, cpu_rst} !== 4'b0101) begin
      errors++;
      $display("FAIL over_status got %b want 0101",
               {done, err, busy, cpu_rst});
    end
  endtask

  task automatic test_zero();
    bq_t b;
    b = add_word(b, 32'd0);
    if (CSUM) b = add_word(b, 32'd0);
    do_reset();
    send(b, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL zero_nwr got %0d want 0", obs_q.size());
    end
    checks++;
    if ({done, err, busy} !== 3'b100) begin
      errors++;
      $display("FAIL zero_status got %b want 100", {done, err, busy});
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t b;
    for (int pass = 0; pass < 2; pass++) begin
      b.delete();
      b = add_word(b, 32'd2);
      b = add_word(b, 32'h0000_0001);
      b = add_word(b, 32'hFFFF_FFFF);
      b = add_word(b, (pass == 0) ? 32'd0 : 32'd1);
      do_reset();
      send(b, 1);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_q.size() != 2) begin
        errors++;
        $display("FAIL csum%0d_nwr got %0d want 2", pass, obs_q.size());
      end
      checks++;
      if ({done, err, cpu_rst} !== ((pass == 0) ? 3'b100 : 3'b011)) begin
        errors++;
        $display("FAIL csum%0d_status got %b want %b", pass,
                 {done, err, cpu_rst}, (pass == 0) ? 3'b100 : 3'b011);
      end
    end
  endtask
`endif

  task automatic test_reset_midload();
    bq_t b;
    bit ed, ee;
    b = add_word(b, 32'd2);
    b = add_word(b, 32'h13);
    b = add_word(b, 32'h6F);
    if (CSUM) b = add_word(b, 32'h82);
    do_reset();
    send(b[0:5], 0);
    do_reset();
    send(b, 1);
    repeat (3) @(negedge clk);
    model(b, ed, ee);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL midrst_nwr got %0d want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL midrst_w%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL midrst_done got %b want 1", done);
    end
  endtask

  task automatic test_random();
    bq_t b;
    bit ed, ee;
    logic [31:0] n, s, w;
    for (int it = 0; it < 10; it++) begin
      b.delete();
      s = 32'd0;
      n = (it == 4) ? 32'(MAXW + 1 + $urandom_range(500, 0))
                    : 32'($urandom_range(6, 0));
      b = add_word(b, n);
      if (n <= MAXW) begin
        for (int i = 0; i < int'(n); i++) begin
          w = $urandom;
          s = s + w;
          b = add_word(b, w);
        end
        if (CSUM) b = add_word(b, ($urandom_range(3, 0) == 0) ? s ^ 32'h10 : s);
      end
      b = add_word(b, $urandom);
      do_reset();
      send(b, 2);
      repeat (3) @(negedge clk);
      model(b, ed, ee);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_nwr got %0d want %0d", it,
                 obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_w%0d got %h want %h", it, i,
                     obs_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if ({done, err, busy} !== {ed, ee, 1'b0}) begin
        errors++;
        $display("FAIL rand%0d_status got %b want %b", it,
                 {done, err, busy}, {ed, ee, 1'b0});
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_oversize();
    test_zero();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream from the UART receive path, assembles little-endian 32-bit words and drives the instruction memory's write port, while holding the CPU core in reset. It sits between `uart_rx` and the write port of the instruction memory array. The memory's synchronous read port, indexed by `pc >> 2`, is the consumer of everything this block writes.

## Interface
Parameters:
- `MAX_WORDS`, 24581: capacity of the instruction memory in 32-bit words.
- `CNT_W`, 15: width of the internal word counter; must satisfy 2^CNT_W ≥ MAX_WORDS.

Ports:
- `clk`  in  1: single clock for the block.
- `rst`  in  1: asynchronous reset, active-high.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid in this cycle.
- `rx_data`  in  8: received byte.
- `imem_we`  out  1: write enable to the instruction memory.
- `imem_waddr`  out  32: byte address, word-aligned (`word_index << 2`), in the same address space as `pc`.
- `imem_wdata`  out  32: write data.
- `busy`  out  1: load in progress.
- `done`  out  1: image loaded successfully; sticky until `rst`.
- `err`  out  1: load aborted; sticky until `rst`.
- `cpu_rst`  out  1: hold-reset for the core; equals `!done`.

## Operation
- The image format is a byte stream:
  - 4-byte word count N, little-endian.
  - N data words, each 4 bytes, little-endian. The first byte of a word goes to bits [7:0].
  - Optional 4-byte checksum; see Configuration.
- FSM states: `S_LEN`, `S_DATA`, `S_CSUM`, `S_DONE`, `S_ERR`. The reset state is `S_LEN`.
- A 2-bit byte counter selects the byte lane. A word is complete when the 4th byte is accepted. The byte counter wraps to 0.
- `S_LEN` transitions, taken when the 4th byte is accepted:
  - N > MAX_WORDS → `S_ERR`.
  - N == 0 → `S_CSUM` if checksum is enabled, else `S_DONE`.
  - Otherwise → `S_DATA`.
- In `S_DATA`, each completed word is written at the current word index, then the index increments. After word N−1 is written → `S_CSUM` or `S_DONE`.
- Writes land at addresses 0, 4, 8, … 4(N−1).
- `S_DONE` and `S_ERR` are terminal. All further `rx_valid` strobes are ignored, and no writes occur.
- Output values after reset:
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `busy`=0, `done`=0, `err`=0, `cpu_rst`=1.
- `busy` is 1 from acceptance of the first length byte until entry to `S_DONE` or `S_ERR`.
- Asserting `rst` mid-load aborts the load and returns the block to `S_LEN`. Words already written stay in memory. The host must resend the whole image.

## Timing
- All outputs are registered.
- Write timing: `imem_we` pulses high for exactly 1 cycle, in the cycle after the edge that accepts the 4th byte of a data word. `imem_waddr` and `imem_wdata` are valid in that same cycle.
- Back-to-back `rx_valid` on every cycle must be accepted without loss. In that case the minimum spacing of `imem_we` pulses is 4 cycles.
- `done` rises one cycle after the final `imem_we` pulse, or one cycle after the last length/checksum byte if N=0. `cpu_rst` falls in that same cycle.
- `err` rises in the cycle after the offending byte is accepted.
- `rx_valid` seen while `rst` is high is ignored.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- When defined:
  - After the last data word, `S_CSUM` collects 4 more bytes (little-endian).
  - The expected value is the sum mod 2^32 of all N data words.
  - Match → `S_DONE`; mismatch → `S_ERR`. Either transition occurs on the 4th checksum byte.
  - The data words are still written to memory before the check. On mismatch, `cpu_rst` remains 1.
- When undefined:
  - The `S_CSUM` state and the accumulator are absent.
  - After the last data word the block goes directly to `S_DONE`. `err` can only arise from N > MAX_WORDS.

## Test plan
- Basic load, macro off: stream 02 00 00 00, 13 00 00 00, 6F 00 00 00 → two `imem_we` pulses: (0x0, 0x00000013) and (0x4, 0x0000006F); `done`=1 and `cpu_rst`=0 one cycle after the second pulse.
- Back-to-back bytes: 3 words streamed with `rx_valid` high every cycle → 3 writes at 0x0/0x4/0x8 spaced 4 cycles apart; data correct and no bytes dropped.
- Oversize: length 0x00006006 (24582) → no `imem_we`; `err`=1; `done`=0; `cpu_rst` stays 1; later bytes ignored.
- Zero length: 00 00 00 00 (plus checksum 00 00 00 00 if the macro is on) → no writes; `done`=1.
- Checksum, macro on: words 0x00000001 and 0xFFFFFFFF with checksum 00 00 00 00 → `done`=1; the same stream with checksum 01 00 00 00 → both words written, `err`=1, `cpu_rst`=1.
- Reset mid-load: assert `rst` after 6 bytes, release it, then send the full basic-load stream → exactly two writes with the correct values, then `done`=1.
